// File: rtl/mmio_pkg.sv
// Shared types and constants for the MMIO interconnect: FSM state encoding,
// the error read-data pattern and the default address-map parameters.
package mmio_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_PERIPH = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    localparam logic [31:0] ERR_DATA         = 32'hDEADBEEF;
    localparam logic [11:0] DEF_MMIO_BASE    = 12'hF00;
    localparam int          DEF_CH_SPAN_LOG2 = 4;

endpackage

// File: rtl/mmio_decode.sv
// Combinational address decoder: splits the processor word address into the
// RAM window and the per-channel MMIO windows above MMIO_BASE.
module mmio_decode
    import mmio_pkg::*;
#(
    parameter int                ADDR_W       = 12,
    parameter int                NUM_CH       = 4,
    parameter logic [ADDR_W-1:0] MMIO_BASE    = ADDR_W'(DEF_MMIO_BASE),
    parameter int                CH_SPAN_LOG2 = DEF_CH_SPAN_LOG2,
    parameter int                IDX_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic [ADDR_W-1:0]       cpu_addr,
    output logic                    ram_hit,
    output logic                    mmio_hit,
    output logic                    unmapped,
    output logic [IDX_W-1:0]        ch_idx,
    output logic [CH_SPAN_LOG2-1:0] ch_off
);

    logic [ADDR_W-1:0] full_idx;

    // Classify the address; the full-width index catches windows beyond the last channel.
    always_comb begin
        ram_hit  = cpu_addr < MMIO_BASE;
        full_idx = (cpu_addr - MMIO_BASE) >> CH_SPAN_LOG2;
        mmio_hit = !ram_hit && (full_idx < ADDR_W'(NUM_CH));
        unmapped = !ram_hit && (full_idx >= ADDR_W'(NUM_CH));
        ch_idx   = full_idx[IDX_W-1:0];
        ch_off   = cpu_addr[CH_SPAN_LOG2-1:0];
    end

endmodule

// File: rtl/mmio_interconnect.sv
// Data-memory interconnect: RAM passthrough plus a req/ack handshake to NUM_CH
// memory-mapped peripheral channels, with a sticky bus-error flag.
// Define MMIO_TIMEOUT_EN to build the PERIPH timeout timer and abort path.
module mmio_interconnect
    import mmio_pkg::*;
#(
    parameter int                ADDR_W       = 12,
    parameter int                DATA_W       = 32,
    parameter int                NUM_CH       = 4,
    parameter logic [ADDR_W-1:0] MMIO_BASE    = ADDR_W'(DEF_MMIO_BASE),
    parameter int                CH_SPAN_LOG2 = DEF_CH_SPAN_LOG2,
    parameter int                TIMEOUT      = 15
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [ADDR_W-1:0]        cpu_addr,
    input  logic [DATA_W-1:0]        cpu_wdata,
    input  logic                     cpu_wren,
    input  logic                     cpu_rden,
    output logic [DATA_W-1:0]        cpu_rdata,
    output logic                     cpu_stall,
    output logic                     ram_wen,
    output logic [ADDR_W-1:0]        ram_addr,
    output logic [DATA_W-1:0]        ram_wdata,
    input  logic [DATA_W-1:0]        ram_rdata,
    output logic [NUM_CH-1:0]        ch_req,
    output logic                     ch_we,
    output logic [CH_SPAN_LOG2-1:0]  ch_addr,
    output logic [DATA_W-1:0]        ch_wdata,
    input  logic [NUM_CH-1:0]        ch_ack,
    input  logic [NUM_CH*DATA_W-1:0] ch_rdata,
    output logic                     bus_err,
    output logic [ADDR_W-1:0]        err_addr
);

    localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    state_t                  state;
    state_t                  state_next;
    logic                    ram_hit;
    logic                    mmio_hit;
    logic                    unmapped;
    logic [IDX_W-1:0]        dec_idx;
    logic [CH_SPAN_LOG2-1:0] dec_off;
    logic [IDX_W-1:0]        idx_q;
    logic [DATA_W-1:0]       rdata_q;
    logic                    access;
    logic                    launch;
    logic                    fault;
    logic                    ack_hit;
    logic                    timeout_hit;

    mmio_decode #(
        .ADDR_W       (ADDR_W),
        .NUM_CH       (NUM_CH),
        .MMIO_BASE    (MMIO_BASE),
        .CH_SPAN_LOG2 (CH_SPAN_LOG2),
        .IDX_W        (IDX_W)
    ) u_decode (
        .cpu_addr (cpu_addr),
        .ram_hit  (ram_hit),
        .mmio_hit (mmio_hit),
        .unmapped (unmapped),
        .ch_idx   (dec_idx),
        .ch_off   (dec_off)
    );

    assign access    = cpu_wren | cpu_rden;
    assign launch    = access && mmio_hit;
    assign fault     = access && unmapped;
    assign ack_hit   = (state == ST_PERIPH) && ch_ack[idx_q];
    assign ram_addr  = cpu_addr;
    assign ram_wdata = cpu_wdata;

`ifdef MMIO_TIMEOUT_EN
    logic [7:0] timer;

    // Count PERIPH cycles so a silent channel cannot hang the processor forever.
    always_ff @(posedge clock) begin
        if (reset) begin
            timer <= '0;
        end else if (state == ST_IDLE) begin
            timer <= '0;
        end else if (state == ST_PERIPH) begin
            timer <= timer + 8'd1;
        end
    end

    assign timeout_hit = (state == ST_PERIPH) && !ch_ack[idx_q] && (timer == 8'(TIMEOUT - 1));
`else
    assign timeout_hit = 1'b0;
`endif

    // State register; reset aborts any transaction in flight.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: launch, wait for ack or abort, then one DONE cycle.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (launch) begin
                    state_next = ST_PERIPH;
                end else if (fault) begin
                    state_next = ST_DONE;
                end
            end
            ST_PERIPH: begin
                if (ack_hit || timeout_hit) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // Channel request registers, read-data capture and sticky error recording.
    always_ff @(posedge clock) begin
        if (reset) begin
            idx_q    <= '0;
            ch_we    <= 1'b0;
            ch_addr  <= '0;
            ch_wdata <= '0;
            rdata_q  <= '0;
            bus_err  <= 1'b0;
            err_addr <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (launch) begin
                        idx_q    <= dec_idx;
                        ch_we    <= cpu_wren;
                        ch_addr  <= dec_off;
                        ch_wdata <= cpu_wdata;
                    end else if (fault) begin
                        rdata_q <= DATA_W'(ERR_DATA);
                        if (!bus_err) begin
                            bus_err  <= 1'b1;
                            err_addr <= cpu_addr;
                        end
                    end
                end
                ST_PERIPH: begin
                    if (ack_hit) begin
                        rdata_q <= ch_rdata[idx_q*DATA_W +: DATA_W];
                    end else if (timeout_hit) begin
                        rdata_q <= DATA_W'(ERR_DATA);
                        if (!bus_err) begin
                            bus_err  <= 1'b1;
                            err_addr <= cpu_addr;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Output decode: RAM passthrough in IDLE, stall while an MMIO access is open.
    always_comb begin
        ch_req    = '0;
        cpu_stall = 1'b0;
        cpu_rdata = rdata_q;
        ram_wen   = 1'b0;
        case (state)
            ST_IDLE: begin
                cpu_stall = access && !ram_hit;
                cpu_rdata = ram_rdata;
                ram_wen   = cpu_wren && ram_hit && !reset;
            end
            ST_PERIPH: begin
                cpu_stall     = 1'b1;
                ch_req[idx_q] = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mmio_interconnect.sv
// Directed self-checking bench for mmio_interconnect with default parameters.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the
// falling edge. Cycle 0 is the cycle in which an access is first presented.
module tb_mmio_interconnect;

    logic         clock = 1'b0;
    logic         reset;
    logic [11:0]  cpu_addr;
    logic [31:0]  cpu_wdata;
    logic         cpu_wren;
    logic         cpu_rden;
    logic [31:0]  cpu_rdata;
    logic         cpu_stall;
    logic         ram_wen;
    logic [11:0]  ram_addr;
    logic [31:0]  ram_wdata;
    logic [31:0]  ram_rdata;
    logic [3:0]   ch_req;
    logic         ch_we;
    logic [3:0]   ch_addr;
    logic [31:0]  ch_wdata;
    logic [3:0]   ch_ack;
    logic [127:0] ch_rdata;
    logic         bus_err;
    logic [11:0]  err_addr;

    int checks = 0;
    int errors = 0;

    logic [31:0] mem [0:4095];

    always #5 clock = ~clock;

    mmio_interconnect #(
        .ADDR_W       (12),
        .DATA_W       (32),
        .NUM_CH       (4),
        .MMIO_BASE    (12'hF00),
        .CH_SPAN_LOG2 (4),
        .TIMEOUT      (15)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_wren  (cpu_wren),
        .cpu_rden  (cpu_rden),
        .cpu_rdata (cpu_rdata),
        .cpu_stall (cpu_stall),
        .ram_wen   (ram_wen),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata),
        .ch_req    (ch_req),
        .ch_we     (ch_we),
        .ch_addr   (ch_addr),
        .ch_wdata  (ch_wdata),
        .ch_ack    (ch_ack),
        .ch_rdata  (ch_rdata),
        .bus_err   (bus_err),
        .err_addr  (err_addr)
    );

    // Synchronous RAM with one-cycle read latency, read-before-write.
    always @(posedge clock) begin
        if (ram_wen) begin
            mem[ram_addr] <= ram_wdata;
        end
        ram_rdata <= mem[ram_addr];
    end

    task automatic applyStimulus(input logic [11:0] a, input logic [31:0] d,
                                 input logic w, input logic r);
        cpu_addr  = a;
        cpu_wdata = d;
        cpu_wren  = w;
        cpu_rden  = r;
    endtask

    task automatic to_drive();
        @(posedge clock);
        #1;
    endtask

    task automatic to_sample();
        @(negedge clock);
    endtask

    task automatic test_reset();
        reset    = 1'b1;
        ch_ack   = '0;
        ch_rdata = '0;
        applyStimulus(12'h020, 32'h5555_5555, 1'b1, 1'b0);
        to_drive();
        to_drive();
        to_sample();
        checks++; if (cpu_stall !== 1'b0) begin errors++; $display("[TB] FAIL rst_stall got=%0h exp=0", cpu_stall); end
        checks++; if (ch_req !== 4'b0000) begin errors++; $display("[TB] FAIL rst_ch_req got=%0h exp=0", ch_req); end
        checks++; if (ch_we !== 1'b0) begin errors++; $display("[TB] FAIL rst_ch_we got=%0h exp=0", ch_we); end
        checks++; if (ch_addr !== 4'h0) begin errors++; $display("[TB] FAIL rst_ch_addr got=%0h exp=0", ch_addr); end
        checks++; if (ch_wdata !== 32'h0) begin errors++; $display("[TB] FAIL rst_ch_wdata got=%0h exp=0", ch_wdata); end
        checks++; if (bus_err !== 1'b0) begin errors++; $display("[TB] FAIL rst_bus_err got=%0h exp=0", bus_err); end
        checks++; if (err_addr !== 12'h0) begin errors++; $display("[TB] FAIL rst_err_addr got=%0h exp=0", err_addr); end
        checks++; if (ram_wen !== 1'b0) begin errors++; $display("[TB] FAIL rst_ram_wen got=%0h exp=0", ram_wen); end
        reset = 1'b0;
        applyStimulus(12'h000, 32'h0, 1'b0, 1'b0);
    endtask

    task automatic test_ram();
        to_drive();
        applyStimulus(12'h010, 32'h1234_5678, 1'b1, 1'b0);
        to_sample();
        checks++; if (ram_wen !== 1'b1) begin errors++; $display("[TB] FAIL ram_wr_wen got=%0h exp=1", ram_wen); end
        checks++; if (cpu_stall !== 1'b0) begin errors++; $display("[TB] FAIL ram_wr_stall got=%0h exp=0", cpu_stall); end
        to_drive();
        applyStimulus(12'h010, 32'h0, 1'b0, 1'b1);
        to_sample();
        checks++; if (cpu_stall !== 1'b0) begin errors++; $display("[TB] FAIL ram_rd_stall got=%0h exp=0", cpu_stall); end
        checks++; if (ram_wen !== 1'b0) begin errors++; $display("[TB] FAIL ram_rd_wen got=%0h exp=0", ram_wen); end
        to_drive();
        applyStimulus(12'h000, 32'h0, 1'b0, 1'b0);
        to_sample();
        checks++; if (cpu_rdata !== 32'h1234_5678) begin errors++; $display("[TB] FAIL ram_rdata got=%0h exp=12345678", cpu_rdata); end
    endtask

    task automatic test_ch1_write();
        to_drive();
        applyStimulus(12'hF13, 32'h0000_00A5, 1'b1, 1'b0);
        to_sample();
        checks++; if (cpu_stall !== 1'b1) begin errors++; $display("[TB] FAIL wr_c0_stall got=%0h exp=1", cpu_stall); end
        checks++; if (ch_req !== 4'b0000) begin errors++; $display("[TB] FAIL wr_c0_req got=%0h exp=0", ch_req); end
        checks++; if (ram_wen !== 1'b0) begin errors++; $display("[TB] FAIL wr_c0_ram_wen got=%0h exp=0", ram_wen); end
        for (int c = 1; c <= 3; c++) begin
            to_drive();
            ch_ack = (c == 3) ? 4'b0010 : 4'b0000;
            to_sample();
            checks++; if (ch_req !== 4'b0010) begin errors++; $display("[TB] FAIL wr_req cycle=%0d got=%0h exp=2", c, ch_req); end
            checks++; if (cpu_stall !== 1'b1) begin errors++; $display("[TB] FAIL wr_stall cycle=%0d got=%0h exp=1", c, cpu_stall); end
            if (c == 1) begin
                checks++; if (ch_addr !== 4'h3) begin errors++; $display("[TB] FAIL wr_ch_addr got=%0h exp=3", ch_addr); end
                checks++; if (ch_we !== 1'b1) begin errors++; $display("[TB] FAIL wr_ch_we got=%0h exp=1", ch_we); end
                checks++; if (ch_wdata !== 32'hA5) begin errors++; $display("[TB] FAIL wr_ch_wdata got=%0h exp=a5", ch_wdata); end
            end
        end
        to_drive();
        ch_ack = 4'b0000;
        to_sample();
        checks++; if (cpu_stall !== 1'b0) begin errors++; $display("[TB] FAIL wr_done_stall got=%0h exp=0", cpu_stall); end
        checks++; if (ch_req !== 4'b0000) begin errors++; $display("[TB] FAIL wr_done_req got=%0h exp=0", ch_req); end
        checks++; if (ram_wen !== 1'b0) begin errors++; $display("[TB] FAIL wr_done_ram_wen got=%0h exp=0", ram_wen); end
    endtask

    task automatic test_ch3_read();
        to_drive();
        ch_rdata[3*32 +: 32] = 32'h0000_CAFE;
        ch_rdata[0 +: 32]    = 32'h0000_1111;
        applyStimulus(12'hF32, 32'h0, 1'b0, 1'b1);
        to_sample();
        checks++; if (cpu_stall !== 1'b1) begin errors++; $display("[TB] FAIL rd_c0_stall got=%0h exp=1", cpu_stall); end
        to_drive();
        ch_ack = 4'b0001;
        to_sample();
        checks++; if (ch_req !== 4'b1000) begin errors++; $display("[TB] FAIL rd_req got=%0h exp=8", ch_req); end
        checks++; if (ch_addr !== 4'h2) begin errors++; $display("[TB] FAIL rd_ch_addr got=%0h exp=2", ch_addr); end
        checks++; if (ch_we !== 1'b0) begin errors++; $display("[TB] FAIL rd_ch_we got=%0h exp=0", ch_we); end
        to_drive();
        ch_ack = 4'b1000;
        to_sample();
        checks++; if (cpu_stall !== 1'b1) begin errors++; $display("[TB] FAIL rd_foreign_ack_stall got=%0h exp=1", cpu_stall); end
        to_drive();
        ch_ack = 4'b0000;
        to_sample();
        checks++; if (cpu_stall !== 1'b0) begin errors++; $display("[TB] FAIL rd_done_stall got=%0h exp=0", cpu_stall); end
        checks++; if (cpu_rdata !== 32'h0000_CAFE) begin errors++; $display("[TB] FAIL rd_rdata got=%0h exp=cafe", cpu_rdata); end
        // Fastest case: ack in cycle 1, data in cycle 2.
        to_drive();
        ch_rdata[3*32 +: 32] = 32'hBEEF_0003;
        applyStimulus(12'hF32, 32'h0, 1'b0, 1'b1);
        to_drive();
        ch_ack = 4'b1000;
        to_sample();
        checks++; if (cpu_stall !== 1'b1) begin errors++; $display("[TB] FAIL rd_fast_c1_stall got=%0h exp=1", cpu_stall); end
        to_drive();
        ch_ack = 4'b0000;
        to_sample();
        checks++; if (cpu_stall !== 1'b0) begin errors++; $display("[TB] FAIL rd_fast_stall got=%0h exp=0", cpu_stall); end
        checks++; if (cpu_rdata !== 32'hBEEF_0003) begin errors++; $display("[TB] FAIL rd_fast_rdata got=%0h exp=beef0003", cpu_rdata); end
    endtask

`ifdef MMIO_TIMEOUT_EN
    task automatic test_timeout();
        to_drive();
        applyStimulus(12'hF05, 32'h0, 1'b0, 1'b1);
        to_sample();
        checks++; if (cpu_stall !== 1'b1) begin errors++; $display("[TB] FAIL to_c0_stall got=%0h exp=1", cpu_stall); end
        for (int c = 1; c <= 15; c++) begin
            to_drive();
            to_sample();
            checks++; if (ch_req !== 4'b0001 || cpu_stall !== 1'b1) begin errors++; $display("[TB] FAIL to_wait cycle=%0d req=%0h stall=%0h exp req=1 stall=1", c, ch_req, cpu_stall); end
        end
        to_drive();
        to_sample();
        checks++; if (ch_req !== 4'b0000) begin errors++; $display("[TB] FAIL to_req_drop got=%0h exp=0", ch_req); end
        checks++; if (cpu_stall !== 1'b0) begin errors++; $display("[TB] FAIL to_done_stall got=%0h exp=0", cpu_stall); end
        checks++; if (cpu_rdata !== 32'hDEAD_BEEF) begin errors++; $display("[TB] FAIL to_rdata got=%0h exp=deadbeef", cpu_rdata); end
        checks++; if (bus_err !== 1'b1) begin errors++; $display("[TB] FAIL to_bus_err got=%0h exp=1", bus_err); end
        checks++; if (err_addr !== 12'hF05) begin errors++; $display("[TB] FAIL to_err_addr got=%0h exp=f05", err_addr); end
    endtask
`else
    task automatic test_no_timeout();
        to_drive();
        ch_rdata[0 +: 32] = 32'h0000_5A5A;
        applyStimulus(12'hF05, 32'h0, 1'b0, 1'b1);
        for (int c = 1; c <= 20; c++) begin
            to_drive();
            to_sample();
            checks++; if (ch_req !== 4'b0001 || cpu_stall !== 1'b1) begin errors++; $display("[TB] FAIL nto_wait cycle=%0d req=%0h stall=%0h exp req=1 stall=1", c, ch_req, cpu_stall); end
        end
        to_drive();
        ch_ack = 4'b0001;
        to_drive();
        ch_ack = 4'b0000;
        to_sample();
        checks++; if (cpu_stall !== 1'b0) begin errors++; $display("[TB] FAIL nto_done_stall got=%0h exp=0", cpu_stall); end
        checks++; if (cpu_rdata !== 32'h0000_5A5A) begin errors++; $display("[TB] FAIL nto_rdata got=%0h exp=5a5a", cpu_rdata); end
        checks++; if (bus_err !== 1'b0) begin errors++; $display("[TB] FAIL nto_bus_err got=%0h exp=0", bus_err); end
    endtask
`endif

    task automatic test_unmapped(input logic [11:0] first_err);
        to_drive();
        applyStimulus(12'hF40, 32'h0, 1'b0, 1'b1);
        to_sample();
        checks++; if (cpu_stall !== 1'b1) begin errors++; $display("[TB] FAIL um_c0_stall got=%0h exp=1", cpu_stall); end
        checks++; if (ch_req !== 4'b0000) begin errors++; $display("[TB] FAIL um_c0_req got=%0h exp=0", ch_req); end
        to_drive();
        to_sample();
        checks++; if (cpu_stall !== 1'b0) begin errors++; $display("[TB] FAIL um_done_stall got=%0h exp=0", cpu_stall); end
        checks++; if (ch_req !== 4'b0000) begin errors++; $display("[TB] FAIL um_done_req got=%0h exp=0", ch_req); end
        checks++; if (cpu_rdata !== 32'hDEAD_BEEF) begin errors++; $display("[TB] FAIL um_rdata got=%0h exp=deadbeef", cpu_rdata); end
        checks++; if (bus_err !== 1'b1) begin errors++; $display("[TB] FAIL um_bus_err got=%0h exp=1", bus_err); end
        checks++; if (err_addr !== first_err) begin errors++; $display("[TB] FAIL um_err_addr got=%0h exp=%0h", err_addr, first_err); end
        to_drive();
        applyStimulus(12'hFF0, 32'h0, 1'b1, 1'b0);
        to_drive();
        to_sample();
        checks++; if (err_addr !== first_err) begin errors++; $display("[TB] FAIL um_sticky_err_addr got=%0h exp=%0h", err_addr, first_err); end
    endtask

    task automatic test_reset_mid();
        to_drive();
        ch_rdata[2*32 +: 32] = 32'h2222_2222;
        applyStimulus(12'hF20, 32'h0, 1'b0, 1'b1);
        to_drive();
        to_sample();
        checks++; if (ch_req !== 4'b0100) begin errors++; $display("[TB] FAIL rm_c1_req got=%0h exp=4", ch_req); end
        to_drive();
        reset = 1'b1;
        to_sample();
        checks++; if (ch_req !== 4'b0100) begin errors++; $display("[TB] FAIL rm_c2_req got=%0h exp=4", ch_req); end
        to_drive();
        reset  = 1'b0;
        ch_ack = 4'b0100;
        applyStimulus(12'h000, 32'h0, 1'b0, 1'b0);
        to_sample();
        checks++; if (ch_req !== 4'b0000) begin errors++; $display("[TB] FAIL rm_req got=%0h exp=0", ch_req); end
        checks++; if (cpu_stall !== 1'b0) begin errors++; $display("[TB] FAIL rm_stall got=%0h exp=0", cpu_stall); end
        checks++; if (bus_err !== 1'b0) begin errors++; $display("[TB] FAIL rm_bus_err got=%0h exp=0", bus_err); end
        checks++; if (err_addr !== 12'h000) begin errors++; $display("[TB] FAIL rm_err_addr got=%0h exp=0", err_addr); end
        to_drive();
        ch_ack = 4'b0000;
        to_sample();
        checks++; if (ch_req !== 4'b0000 || cpu_stall !== 1'b0) begin errors++; $display("[TB] FAIL rm_late_ack req=%0h stall=%0h exp req=0 stall=0", ch_req, cpu_stall); end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        test_reset();
        test_ram();
        test_ch1_write();
        test_ch3_read();
`ifdef MMIO_TIMEOUT_EN
        test_timeout();
        test_unmapped(12'hF05);
`else
        test_no_timeout();
        test_unmapped(12'hF40);
`endif
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
